decoder_demux_bank: RTL and testbench

DECODER_DEMUX_BANK -- requirements
Module: decoder_demux_bank

---
 rtl/decoder_demux_bank_if.sv | 25 ++
 rtl/decoder_demux_bank.sv | 62 ++++++
 tb/tb_decoder_demux_bank.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/decoder_demux_bank_if.sv
// Bundle of the decoder/demux bank's qualified inputs and its result outputs.
// The slave side is the bank itself; the master side drives inputs and observes results.
interface decoder_demux_bank_if;
  logic       in_valid;
  logic       dec_en;
  logic       dec_sel;
  logic       dec4_en;
  logic [1:0] dec4_sel;
  logic       demux_in;
  logic       demux_sel;
  logic [1:0] dec_out;
  logic [3:0] dec4_out;
  logic [1:0] demux_out;
  logic       out_valid;

  modport slave (
    input  in_valid, dec_en, dec_sel, dec4_en, dec4_sel, demux_in, demux_sel,
    output dec_out, dec4_out, demux_out, out_valid
  );

  modport master (
    output in_valid, dec_en, dec_sel, dec4_en, dec4_sel, demux_in, demux_sel,
    input  dec_out, dec4_out, demux_out, out_valid
  );
endinterface

// File: rtl/decoder_demux_bank.sv
// Three independent units: a 1:2 decoder, a 2:4 decoder and a 1:2 demux.
// REG_OUT selects one-cycle registered results or purely combinational ones.
module decoder_demux_bank #(
  parameter bit REG_OUT = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  decoder_demux_bank_if.slave  bus
);

  logic [1:0] dec_next;
  logic [3:0] dec4_next;
  logic [1:0] demux_next;

  // Shifting a single set bit by the select keeps decoder codes strictly one-hot or zero.
  always_comb begin
    dec_next   = 2'b00;
    dec4_next  = 4'b0000;
    demux_next = 2'b00;
    if (bus.dec_en)  dec_next  = 2'b01 << bus.dec_sel;
    if (bus.dec4_en) dec4_next = 4'b0001 << bus.dec4_sel;
    demux_next = {1'b0, bus.demux_in} << bus.demux_sel;
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [1:0] dec_q;
      logic [3:0] dec4_q;
      logic [1:0] demux_q;
      logic       valid_q;

      // Data captures only on valid cycles and otherwise holds; valid tracks in_valid.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dec_q   <= 2'b00;
          dec4_q  <= 4'b0000;
          demux_q <= 2'b00;
          valid_q <= 1'b0;
        end else begin
          valid_q <= bus.in_valid;
          if (bus.in_valid) begin
            dec_q   <= dec_next;
            dec4_q  <= dec4_next;
            demux_q <= demux_next;
          end
        end
      end

      assign bus.dec_out   = dec_q;
      assign bus.dec4_out  = dec4_q;
      assign bus.demux_out = demux_q;
      assign bus.out_valid = valid_q;
    end else begin : g_comb
      // Data follows inputs regardless of in_valid or reset; only out_valid is gated.
      assign bus.dec_out   = dec_next;
      assign bus.dec4_out  = dec4_next;
      assign bus.demux_out = demux_next;
      assign bus.out_valid = bus.in_valid & ~rst;
    end
  endgenerate

endmodule

// File: tb/tb_decoder_demux_bank.sv
// Bench for decoder_demux_bank: registered and combinational instances share one stimulus
// stream, checked every cycle against a behavioural model plus hand-computed literals.
module tb_decoder_demux_bank;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   cmp_en   = 1'b0;

  decoder_demux_bank_if bus_r();
  decoder_demux_bank_if bus_c();

  decoder_demux_bank #(.REG_OUT(1'b1)) u_reg  (.clk(clk), .rst(rst), .bus(bus_r.slave));
  decoder_demux_bank #(.REG_OUT(1'b0)) u_comb (.clk(clk), .rst(rst), .bus(bus_c.slave));

  always #5 clk = ~clk;

  assign bus_c.in_valid  = bus_r.in_valid;
  assign bus_c.dec_en    = bus_r.dec_en;
  assign bus_c.dec_sel   = bus_r.dec_sel;
  assign bus_c.dec4_en   = bus_r.dec4_en;
  assign bus_c.dec4_sel  = bus_r.dec4_sel;
  assign bus_c.demux_in  = bus_r.demux_in;
  assign bus_c.demux_sel = bus_r.demux_sel;

  // Model: a selected position holds the value 2**sel when the unit is enabled.
  function automatic logic [3:0] onehot(input logic en, input int idx);
    return en ? 4'(2 ** idx) : 4'd0;
  endfunction

  logic [1:0] m_dec, m_demux;
  logic [3:0] m_dec4;
  logic       m_valid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_dec <= 2'd0; m_dec4 <= 4'd0; m_demux <= 2'd0; m_valid <= 1'b0;
    end else begin
      m_valid <= bus_r.in_valid;
      if (bus_r.in_valid) begin
        m_dec   <= 2'(onehot(bus_r.dec_en, int'(bus_r.dec_sel)));
        m_dec4  <= onehot(bus_r.dec4_en, int'(bus_r.dec4_sel));
        m_demux <= 2'(onehot(bus_r.demux_in, int'(bus_r.demux_sel)));
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("reg_dec",     32'(bus_r.dec_out),   32'(m_dec));
      checkOutput("reg_dec4",    32'(bus_r.dec4_out),  32'(m_dec4));
      checkOutput("reg_demux",   32'(bus_r.demux_out), 32'(m_demux));
      checkOutput("reg_valid",   32'(bus_r.out_valid), 32'(m_valid));
      checkOutput("comb_dec",    32'(bus_c.dec_out),
                  32'(onehot(bus_r.dec_en, int'(bus_r.dec_sel))));
      checkOutput("comb_dec4",   32'(bus_c.dec4_out),
                  32'(onehot(bus_r.dec4_en, int'(bus_r.dec4_sel))));
      checkOutput("comb_demux",  32'(bus_c.demux_out),
                  32'(onehot(bus_r.demux_in, int'(bus_r.demux_sel))));
      checkOutput("comb_valid",  32'(bus_c.out_valid), 32'(bus_r.in_valid & ~rst));
    end
  end

  // dec = {en, sel}, dec4 = {en, sel[1:0]}, dmx = {in, sel}; lands 2 time units after a rising edge.
  task automatic applyStimulus(input logic v, input logic [1:0] dec, input logic [2:0] dec4,
                               input logic [1:0] dmx);
    @(posedge clk);
    #2;
    bus_r.in_valid  = v;
    {bus_r.dec_en, bus_r.dec_sel}     = dec;
    {bus_r.dec4_en, bus_r.dec4_sel}   = dec4;
    {bus_r.demux_in, bus_r.demux_sel} = dmx;
  endtask

  task automatic checkReg(input string tag, input logic [1:0] d, input logic [3:0] d4,
                          input logic [1:0] dm, input logic ov);
    checkOutput({tag, "_dec"},   32'(bus_r.dec_out),   32'(d));
    checkOutput({tag, "_dec4"},  32'(bus_r.dec4_out),  32'(d4));
    checkOutput({tag, "_demux"}, 32'(bus_r.demux_out), 32'(dm));
    checkOutput({tag, "_valid"}, 32'(bus_r.out_valid), 32'(ov));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] dec4_tab [4];
    logic [1:0] dmx_tab  [4];
    dec4_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    dmx_tab  = '{2'b00, 2'b00, 2'b01, 2'b10};

    bus_r.in_valid = 1'b0;
    {bus_r.dec_en, bus_r.dec_sel}     = 2'b00;
    {bus_r.dec4_en, bus_r.dec4_sel}   = 3'b000;
    {bus_r.demux_in, bus_r.demux_sel} = 2'b00;
    rst = 1'b1;

    // Reset pulse entirely between clock edges
    #1;
    checkReg("rst_async", 2'b00, 4'b0000, 2'b00, 1'b0);
    checkOutput("rst_comb_valid", 32'(bus_c.out_valid), 32'd0);
    #2 rst = 1'b0;
    cmp_en = 1'b1;

    applyStimulus(1'b0, 2'b00, 3'b000, 2'b00);
    applyStimulus(1'b1, 2'b11, 3'b000, 2'b00);
    applyStimulus(1'b1, 2'b01, 3'b000, 2'b00);
    checkReg("dec_sel1", 2'b10, 4'b0000, 2'b00, 1'b1);
    applyStimulus(1'b0, 2'b00, 3'b000, 2'b00);
    checkReg("dec_off", 2'b00, 4'b0000, 2'b00, 1'b1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'b00, {1'b1, 2'(i)}, 2'b00);
      if (i > 0) checkOutput("dec4_sweep", 32'(bus_r.dec4_out), 32'(dec4_tab[i-1]));
    end
    applyStimulus(1'b1, 2'b00, 3'b011, 2'b00);
    checkOutput("dec4_sweep", 32'(bus_r.dec4_out), 32'(dec4_tab[3]));
    applyStimulus(1'b0, 2'b00, 3'b000, 2'b00);
    checkOutput("dec4_off", 32'(bus_r.dec4_out), 32'd0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'b00, 3'b000, 2'(i));
      if (i > 0) checkOutput("demux_sweep", 32'(bus_r.demux_out), 32'(dmx_tab[i-1]));
    end
    applyStimulus(1'b0, 2'b00, 3'b000, 2'b00);
    checkOutput("demux_sweep", 32'(bus_r.demux_out), 32'(dmx_tab[3]));

    // Hold while invalid and inputs keep changing
    applyStimulus(1'b1, 2'b10, 3'b110, 2'b11);
    applyStimulus(1'b0, 2'b11, 3'b101, 2'b10);
    checkReg("hold0", 2'b01, 4'b0100, 2'b10, 1'b1);
    applyStimulus(1'b0, 2'b10, 3'b111, 2'b01);
    checkReg("hold1", 2'b01, 4'b0100, 2'b10, 1'b0);
    applyStimulus(1'b0, 2'b00, 3'b000, 2'b11);
    checkReg("hold2", 2'b01, 4'b0100, 2'b10, 1'b0);
    applyStimulus(1'b0, 2'b11, 3'b100, 2'b00);
    checkReg("hold3", 2'b01, 4'b0100, 2'b10, 1'b0);

    // Only dec4 and demux inputs change; dec_out must be unaffected
    applyStimulus(1'b1, 2'b11, 3'b100, 2'b00);
    applyStimulus(1'b1, 2'b11, 3'b111, 2'b10);
    checkReg("indep0", 2'b10, 4'b0001, 2'b00, 1'b1);
    applyStimulus(1'b0, 2'b11, 3'b111, 2'b10);
    checkReg("indep1", 2'b10, 4'b1000, 2'b01, 1'b1);

    // Reset lands before the edge that would capture a valid input
    applyStimulus(1'b1, 2'b11, 3'b111, 2'b11);
    #2 rst = 1'b1;
    #1;
    checkReg("rst_mid", 2'b00, 4'b0000, 2'b00, 1'b0);
    checkOutput("rst_comb_dec", 32'(bus_c.dec_out), 32'(2'b10));
    checkOutput("rst_comb_valid2", 32'(bus_c.out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkReg("rst_edge", 2'b00, 4'b0000, 2'b00, 1'b0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    checkReg("rst_release", 2'b10, 4'b1000, 2'b10, 1'b1);

    applyStimulus(1'b0, 2'b00, 3'b000, 2'b00);
    applyStimulus(1'b0, 2'b00, 3'b000, 2'b00);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
